uart_rx_frame: RTL and testbench

- Asynchronous-serial (UART 8N1) frame receiver.
- Sits directly downstream of the input synchronizer/spike filter and consumes its clean, clock-synchronous `stable_out` line as `rx`.
- Detects start bits, samples each bit at its midpoint, and assembles 8 data bits LSB first.
- Per frame, emits either a one-cycle data-valid pulse or a one-cycle framing-error pulse.

---
 rtl/uart_rx_frame.sv | 135 +++++++++++++
 tb/tb_uart_rx_frame.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
`default_nettype none
// =============================================================================
// Module   : uart_rx_frame
// Purpose  : 8N1 UART frame receiver; mid-bit sampling of a pre-filtered line.
// Revision : 1.0
// =============================================================================
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_error,
    output logic       rx_busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ZERO  = '0;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_STOP  = 3'd3;
    localparam logic [2:0] c_BREAK = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       idx_q,   idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q,  data_d;
    logic             ready_q, ready_d;
    logic             ferr_q,  ferr_d;
    logic             busy_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            c_IDLE: begin
                cnt_d = c_CNT_ZERO;
                if (!rx) begin
                    state_d = c_START;
                end
            end
            c_START: begin
                if (cnt_q == c_HALF_LAST) begin
                    cnt_d   = c_CNT_ZERO;
                    idx_d   = 3'd0;
                    state_d = rx ? c_IDLE : c_DATA;
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            c_DATA: begin
                if (cnt_q == c_CNT_LAST) begin
                    cnt_d   = c_CNT_ZERO;
                    shift_d = {rx, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = c_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            c_STOP: begin
                // Leaving mid-stop-bit lets a back-to-back start bit be seen promptly.
                if (cnt_q == c_CNT_LAST) begin
                    cnt_d = c_CNT_ZERO;
                    if (rx) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = c_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = c_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + c_CNT_ONE;
                end
            end
            c_BREAK: begin
                cnt_d = c_CNT_ZERO;
                if (rx) begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
                cnt_d   = c_CNT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            cnt_q   <= c_CNT_ZERO;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            busy_q  <= (state_d != c_IDLE);
        end
    end

    assign rx_data     = data_q;
    assign rx_ready    = ready_q;
    assign frame_error = ferr_q;
    assign rx_busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// Module   : tb_uart_rx_frame
// Purpose  : Self-checking bench for uart_rx_frame (fast and default bit rates).
// Revision : 1.0
// =============================================================================
module tb_uart_rx_frame;

    localparam int CPB     = 16;
    localparam int HALF    = CPB / 2;
    localparam int CPB_DEF = 868;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx2;
    logic [7:0] rx_data,  rx_data2;
    logic       rx_ready, rx_ready2;
    logic       frame_error, frame_error2;
    logic       rx_busy,  rx_busy2;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    int busy_cyc = 0;

    typedef struct {
        int         t;
        logic [7:0] d;
        logic       err;
    } ev_t;
    ev_t evq[$];

    int         r2_cnt = 0;
    int         e2_cnt = 0;
    int         r2_t   = 0;
    logic [7:0] r2_d   = 8'h00;
    logic       prev_pulse = 1'b0;

    always #5 clk = ~clk;

    uart_rx_frame #(.CLKS_PER_BIT(CPB)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .frame_error(frame_error),
        .rx_busy    (rx_busy)
    );

    uart_rx_frame u_dut_def (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx2),
        .rx_data    (rx_data2),
        .rx_ready   (rx_ready2),
        .frame_error(frame_error2),
        .rx_busy    (rx_busy2)
    );

    // Edge-numbered monitor: ncyc names the rising edge whose results are visible.
    always @(posedge clk) begin
        #1;
        ncyc++;
        if (rx_ready || frame_error) begin
            checks++;
            if (rx_ready && frame_error) begin
                errors++;
                $display("FAIL pulse_exclusive t=%0d ready=%b ferr=%b want not both", ncyc, rx_ready, frame_error);
            end
            checks++;
            if (prev_pulse) begin
                errors++;
                $display("FAIL pulse_width t=%0d pulse high for 2 cycles, want 1", ncyc);
            end
            evq.push_back('{t: ncyc, d: rx_data, err: frame_error});
        end
        prev_pulse = rx_ready || frame_error;
        if (rx_busy) busy_cyc++;
        if (rx_ready2) begin
            r2_cnt++;
            r2_t = ncyc;
            r2_d = rx_data2;
        end
        if (frame_error2) e2_cnt++;
    end

    task automatic hold(input int which, input logic v, input int n);
        if (which == 0) rx = v; else rx2 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input int cpb, input logic [7:0] b,
                              input logic stop, output int t0);
        t0 = ncyc + 1;
        hold(which, 1'b0, cpb);
        for (int i = 0; i < 8; i++) hold(which, b[i], cpb);
        hold(which, stop, cpb);
    endtask

    task automatic pop_ev(output logic found, output ev_t e);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            found = 1'b1;
        end else begin
            e = '{t: 0, d: 8'h00, err: 1'b0};
            found = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; rx = 1'b1; rx2 = 1'b1;
        repeat (3) @(negedge clk);
        checks += 5;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b want 0", rx_ready); end
        if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_error); end
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", rx_busy); end
        if (rx_data2 !== 8'h00) begin errors++; $display("FAIL reset_rx_data_def got %h want 00", rx_data2); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_false_start;
        busy_cyc = 0;
        hold(0, 1'b0, 5);
        hold(0, 1'b1, 200);
        checks += 3;
        if (busy_cyc != HALF) begin errors++; $display("FAIL false_start_busy got %0d cycles want %0d", busy_cyc, HALF); end
        if (evq.size() != 0) begin errors++; $display("FAIL false_start_events got %0d want 0", evq.size()); end
        if (rx_data !== 8'h00) begin errors++; $display("FAIL false_start_data got %h want 00", rx_data); end
        evq.delete();
    endtask

    task automatic test_frame_a5;
        int t0; logic found; ev_t e;
        busy_cyc = 0;
        send_frame(0, CPB, 8'hA5, 1'b1, t0);
        hold(0, 1'b1, 4);
        pop_ev(found, e);
        checks += 7;
        if (!found) begin errors++; $display("FAIL a5_event got none want one"); end
        if (e.t != t0 + HALF + 9 * CPB) begin errors++; $display("FAIL a5_time got %0d want %0d", e.t, t0 + HALF + 9 * CPB); end
        if (e.err !== 1'b0) begin errors++; $display("FAIL a5_kind got ferr=%b want 0", e.err); end
        if (e.d !== 8'hA5) begin errors++; $display("FAIL a5_data got %h want a5", e.d); end
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL a5_busy_after got %b want 0", rx_busy); end
        if (busy_cyc != HALF + 9 * CPB) begin errors++; $display("FAIL a5_busy_len got %0d want %0d", busy_cyc, HALF + 9 * CPB); end
        if (evq.size() != 0) begin errors++; $display("FAIL a5_extra got %0d want 0", evq.size()); end
        evq.delete();
    endtask

    task automatic test_break;
        int t0; logic found; ev_t e;
        busy_cyc = 0;
        send_frame(0, CPB, 8'h3C, 1'b0, t0);
        hold(0, 1'b0, 40);
        checks++;
        if (rx_busy !== 1'b1) begin errors++; $display("FAIL break_busy_low_line got %b want 1", rx_busy); end
        hold(0, 1'b1, 200);
        pop_ev(found, e);
        checks += 7;
        if (!found) begin errors++; $display("FAIL break_event got none want one"); end
        if (e.t != t0 + HALF + 9 * CPB) begin errors++; $display("FAIL break_time got %0d want %0d", e.t, t0 + HALF + 9 * CPB); end
        if (e.err !== 1'b1) begin errors++; $display("FAIL break_kind got ferr=%b want 1", e.err); end
        if (rx_data !== 8'hA5) begin errors++; $display("FAIL break_data got %h want a5", rx_data); end
        if (busy_cyc != 10 * CPB + 40) begin errors++; $display("FAIL break_busy_len got %0d want %0d", busy_cyc, 10 * CPB + 40); end
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL break_busy_after got %b want 0", rx_busy); end
        if (evq.size() != 0) begin errors++; $display("FAIL break_spurious got %0d events want 0", evq.size()); end
        evq.delete();
    endtask

    task automatic test_back_to_back;
        int ta, tb; logic f1, f2; ev_t e1, e2;
        send_frame(0, CPB, 8'h00, 1'b1, ta);
        send_frame(0, CPB, 8'hFF, 1'b1, tb);
        hold(0, 1'b1, 5);
        pop_ev(f1, e1);
        pop_ev(f2, e2);
        checks += 7;
        if (!(f1 && f2)) begin errors++; $display("FAIL b2b_count got %0d%0d want 11", f1, f2); end
        if (e1.t != ta + HALF + 9 * CPB) begin errors++; $display("FAIL b2b_time1 got %0d want %0d", e1.t, ta + HALF + 9 * CPB); end
        if (e2.t - e1.t != 10 * CPB) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", e2.t - e1.t, 10 * CPB); end
        if (e1.d !== 8'h00 || e1.err !== 1'b0) begin errors++; $display("FAIL b2b_data1 got %h/%b want 00/0", e1.d, e1.err); end
        if (e2.d !== 8'hFF || e2.err !== 1'b0) begin errors++; $display("FAIL b2b_data2 got %h/%b want ff/0", e2.d, e2.err); end
        if (rx_data !== 8'hFF) begin errors++; $display("FAIL b2b_final got %h want ff", rx_data); end
        if (evq.size() != 0) begin errors++; $display("FAIL b2b_extra got %0d want 0", evq.size()); end
        evq.delete();
    endtask

    task automatic test_reset_mid;
        int t0; logic found; ev_t e;
        logic [7:0] b;
        b = 8'h5A;
        hold(0, 1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(0, b[i], CPB);
        hold(0, b[4], CPB / 2);
        rst = 1'b1;
        @(negedge clk);
        checks += 4;
        if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %h want 00", rx_data); end
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", rx_ready); end
        if (frame_error !== 1'b0) begin errors++; $display("FAIL midrst_ferr got %b want 0", frame_error); end
        if (rx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", rx_busy); end
        rst = 1'b0;
        hold(0, 1'b1, 200);
        checks++;
        if (evq.size() != 0) begin errors++; $display("FAIL midrst_spurious got %0d want 0", evq.size()); end
        evq.delete();
        send_frame(0, CPB, 8'h81, 1'b1, t0);
        hold(0, 1'b1, 4);
        pop_ev(found, e);
        checks += 4;
        if (!found || e.err !== 1'b0) begin errors++; $display("FAIL post_rst_event found=%b ferr=%b want 1/0", found, e.err); end
        if (e.t != t0 + HALF + 9 * CPB) begin errors++; $display("FAIL post_rst_time got %0d want %0d", e.t, t0 + HALF + 9 * CPB); end
        if (rx_data !== 8'h81) begin errors++; $display("FAIL post_rst_data got %h want 81", rx_data); end
        if (evq.size() != 0) begin errors++; $display("FAIL post_rst_extra got %0d want 0", evq.size()); end
        evq.delete();
    endtask

    // Reference: each frame yields exactly one event HALF+9*CPB edges after its start edge.
    task automatic test_random;
        int t0; logic found; ev_t e;
        logic [7:0] b, last_good;
        logic stop;
        last_good = rx_data === 8'h81 ? 8'h81 : 8'hxx;
        last_good = 8'h81;
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(0, CPB, b, stop, t0);
            if (stop) begin
                hold(0, 1'b1, $urandom_range(0, 12));
                last_good = b;
            end else begin
                hold(0, 1'b0, $urandom_range(0, 10));
                hold(0, 1'b1, $urandom_range(1, 12));
            end
            pop_ev(found, e);
            checks += 4;
            if (!found) begin errors++; $display("FAIL rand%0d_event got none want one", n); end
            if (e.t != t0 + HALF + 9 * CPB) begin errors++; $display("FAIL rand%0d_time got %0d want %0d", n, e.t, t0 + HALF + 9 * CPB); end
            if (e.err !== !stop) begin errors++; $display("FAIL rand%0d_kind got ferr=%b want %b", n, e.err, !stop); end
            if (e.d !== last_good) begin errors++; $display("FAIL rand%0d_data got %h want %h", n, e.d, last_good); end
        end
        hold(0, 1'b1, 20);
        checks += 2;
        if (evq.size() != 0) begin errors++; $display("FAIL rand_extra got %0d want 0", evq.size()); end
        if (rx_data !== last_good) begin errors++; $display("FAIL rand_final got %h want %h", rx_data, last_good); end
        evq.delete();
    endtask

    task automatic test_default_rate;
        int t0;
        send_frame(1, CPB_DEF, 8'h55, 1'b1, t0);
        hold(1, 1'b1, 10);
        checks += 4;
        if (r2_cnt != 1) begin errors++; $display("FAIL def_count got %0d want 1", r2_cnt); end
        if (r2_t - t0 != 8246) begin errors++; $display("FAIL def_latency got %0d want 8246", r2_t - t0); end
        if (r2_d !== 8'h55) begin errors++; $display("FAIL def_data got %h want 55", r2_d); end
        if (e2_cnt != 0) begin errors++; $display("FAIL def_ferr got %0d want 0", e2_cnt); end
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; rx2 = 1'b1;
        @(negedge clk);
        test_reset();
        test_false_start();
        test_frame_a5();
        test_break();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_default_rate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
